// File: rtl/hansen_mem_arbiter_pkg.sv
// rtl/hansen_mem_arbiter_pkg.sv - shared FSM encodings and constants for the hansen memory arbiter
package hansen_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam logic [31:0] HANSEN_BUS_ERR_DATA = 32'hDEADBEEF;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hansen_mem_arbiter_rr_picker.sv
// rtl/hansen_mem_arbiter_rr_picker.sv - rotate-priority picker: first valid at or after ptr wins
module hansen_rr_picker
  import hansen_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic             found;
  logic [IDX_W-1:0] sel;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && valid_i[sel]) begin
        found        = 1'b1;
        grant_o[sel] = 1'b1;
        idx_o        = sel;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/hansen_mem_arbiter.sv
// rtl/hansen_mem_arbiter.sv - round-robin single-outstanding memory arbiter with timeout bus error
// Optional HANSEN_ARB_LOCK_EN adds req_lock_i for atomic read-modify-write sequences.
module hansen_mem_arbiter
  import hansen_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
`ifdef HANSEN_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock_i,
`endif
  output logic [NUM_REQ-1:0]        resp_valid_o,
  output logic [DATA_W-1:0]         resp_rdata_o,
  output logic                      resp_err_o,
  output logic                      mem_valid_o,
  input  logic                      mem_ready_i,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_W-1:0]         mem_rdata_i
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic [15:0]        timer_q, timer_d, timer_inc;
  logic               mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d, resp_rdata_q, resp_rdata_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0] pick_valid, grant_oh;
  logic [IDX_W-1:0]   grant_idx, ptr_next;
  logic               grant_any, rsp_hit, timeout_hit, lock_act;

  hansen_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .valid_i (pick_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_oh),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign ptr_next  = IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
  assign timer_inc = timer_q + 16'd1;
  // A read can complete in the same cycle the request is accepted.
  assign rsp_hit     = ((state_q == ST_ISSUE) && mem_ready_i && mem_rvalid_i) ||
                       ((state_q == ST_WAIT) && mem_rvalid_i);
  assign timeout_hit = (state_q != ST_IDLE) && (timer_inc == 16'(TIMEOUT));

`ifdef HANSEN_ARB_LOCK_EN
  logic lock_q, lock_d;

  assign lock_act   = lock_q && req_lock_i[owner_q];
  assign pick_valid = lock_act ? (req_valid_i & (NUM_REQ'(1) << owner_q)) : req_valid_i;

  always_comb begin
    lock_d = lock_q;
    if ((state_q == ST_IDLE) && !lock_act) lock_d = 1'b0;
    if (rsp_hit || timeout_hit) lock_d = req_lock_i[owner_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lock_q <= 1'b0;
    else         lock_q <= lock_d;
  end
`else
  assign lock_act   = 1'b0;
  assign pick_valid = req_valid_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      timer_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      timer_q      <= timer_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_any) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (rsp_hit || timeout_hit) state_d = ST_IDLE;
        else if (mem_ready_i)       state_d = ST_WAIT;
      end
      ST_WAIT:  if (rsp_hit || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    timer_d      = timer_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_valid_d = '0;
    resp_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          mem_valid_d = 1'b1;
          mem_we_d    = req_we_i[grant_idx];
          mem_addr_d  = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
          mem_wdata_d = req_wdata_i[grant_idx*DATA_W +: DATA_W];
          owner_d     = grant_idx;
          timer_d     = '0;
          if (!lock_act) rr_ptr_d = ptr_next;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        timer_d = timer_inc;
        if ((state_q == ST_ISSUE) && mem_ready_i) mem_valid_d = 1'b0;
        if (rsp_hit) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_rdata_d          = mem_we_q ? '0 : mem_rdata_i;
        end else if (timeout_hit) begin
          mem_valid_d           = 1'b0;
          resp_valid_d[owner_q] = 1'b1;
          resp_err_d            = 1'b1;
          resp_rdata_d          = DATA_W'(HANSEN_BUS_ERR_DATA);
        end
      end
      default: ;
    endcase
  end

  assign req_ready_o  = (state_q == ST_IDLE) ? grant_oh : '0;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_hansen_mem_arbiter.sv
// tb/tb_hansen_mem_arbiter.sv - directed self-checking bench for hansen_mem_arbiter
module tb_hansen_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready, req_we, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          resp_err, mem_valid, mem_ready, mem_we, mem_rvalid;
`ifdef HANSEN_ARB_LOCK_EN
  logic [N-1:0]  req_lock;
`endif

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_g, prev_g;

  always #5 clk = ~clk;

  hansen_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
`ifdef HANSEN_ARB_LOCK_EN
    .req_lock_i   (req_lock),
`endif
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_valid_o  (mem_valid),
    .mem_ready_i  (mem_ready),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  req_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_err"},   resp_err, 0);
    check({tag, "_resp_rdata"}, resp_rdata, 0);
    check({tag, "_mem_valid"},  mem_valid, 0);
    check({tag, "_mem_we"},     mem_we, 0);
    check({tag, "_mem_addr"},   mem_addr, 0);
    check({tag, "_mem_wdata"},  mem_wdata, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
`ifdef HANSEN_ARB_LOCK_EN
    req_lock = '0;
`endif
    tick(); tick();
    check_all_zero("rst");
    rst_n = 1'b1;

    // single read against a zero-wait memory
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h002080B3;
    req_addr[0 +: AW] = 32'h0000000C; req_valid = 2'b01; #1;
    check("rd_ready", req_ready, 2'b01);
    tick(); req_valid = '0;
    check("rd_mem_valid", mem_valid, 1);
    check("rd_mem_addr", mem_addr, 32'h0000000C);
    check("rd_mem_we", mem_we, 0);
    check("rd_resp_early", resp_valid, 0);
    tick();
    check("rd_resp_valid", resp_valid, 2'b01);
    check("rd_resp_rdata", resp_rdata, 32'h002080B3);
    check("rd_resp_err", resp_err, 0);
    tick();
    check("rd_resp_pulse", resp_valid, 0);

    // contention from reset: both requesters valid for 6 transactions
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_addr = {32'h00000200, 32'h00000100}; mem_rdata = 32'h000000AA;
    req_valid = 2'b11; prev_g = '0;
    for (int t = 0; t < 6; t++) begin
      #1;
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("cont_grant%0d", t), req_ready, exp_g);
      if (t > 0) check($sformatf("cont_resp%0d", t), resp_valid, prev_g);
      prev_g = exp_g;
      tick();
      check($sformatf("cont_addr%0d", t), mem_addr, (t % 2 == 0) ? 32'h100 : 32'h200);
      check($sformatf("cont_issue_ready%0d", t), req_ready, 0);
      if (t == 5) req_valid = '0;
      tick();
    end
    check("cont_last_resp", resp_valid, 2'b10);

    // write from req1, memory stalls mem_ready for two cycles
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h12345678;
    req_we = 2'b10; req_addr[AW +: AW] = 32'h00000010; req_wdata[DW +: DW] = 32'h00500113;
    req_valid = 2'b10; #1;
    check("wr_ready", req_ready, 2'b10);
    tick(); req_valid = '0; req_we = '0;
    check("wr_mem_valid", mem_valid, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 32'h10);
    check("wr_mem_wdata", mem_wdata, 32'h00500113);
    tick();
    check("wr_hold_valid", mem_valid, 1);
    check("wr_hold_addr", mem_addr, 32'h10);
    check("wr_hold_we", mem_we, 1);
    mem_ready = 1'b1;
    tick(); mem_ready = 1'b0;
    check("wr_valid_drop", mem_valid, 0);
    check("wr_no_resp_yet", resp_valid, 0);
    mem_rvalid = 1'b1;
    tick(); mem_rvalid = 1'b0;
    check("wr_resp_valid", resp_valid, 2'b10);
    check("wr_resp_rdata", resp_rdata, 0);
    check("wr_resp_err", resp_err, 0);
    tick();
    check("wr_resp_pulse", resp_valid, 0);

    // timeout: memory never accepts
    req_addr[0 +: AW] = 32'h00000020; req_valid = 2'b01; #1;
    check("to_ready", req_ready, 2'b01);
    tick(); req_valid = '0;
    for (int k = 0; k < TO; k++) begin
      check($sformatf("to_mem_valid%0d", k), mem_valid, 1);
      check($sformatf("to_no_resp%0d", k), resp_valid, 0);
      tick();
    end
    check("to_resp_valid", resp_valid, 2'b01);
    check("to_resp_err", resp_err, 1);
    check("to_resp_rdata", resp_rdata, 32'hDEADBEEF);
    check("to_mem_valid_drop", mem_valid, 0);
    tick();
    check("to_resp_pulse", resp_valid, 0);
    check("to_err_pulse", resp_err, 0);

    // reset while waiting for read data
    mem_ready = 1'b1; req_addr[AW +: AW] = 32'h00000040; req_valid = 2'b10; #1;
    check("rw_ready_idle", req_ready, 2'b10);
    tick(); req_valid = '0;
    tick(); mem_ready = 1'b0;
    check("rw_in_wait", mem_valid, 0);
    rst_n = 1'b0; #1;
    check_all_zero("rw_reset");
    mem_rvalid = 1'b1; mem_rdata = 32'h00000055;
    tick(); rst_n = 1'b1;
    tick();
    check("rw_stale_resp0", resp_valid, 0);
    tick();
    check("rw_stale_resp1", resp_valid, 0);
    check("rw_stale_rdata", resp_rdata, 0);
    mem_ready = 1'b1; req_addr = {32'h00000080, 32'h00000060}; req_valid = 2'b11; #1;
    check("rw_next_grant", req_ready, 2'b01);
    tick(); req_valid = '0;
    check("rw_next_addr", mem_addr, 32'h60);
    tick();
    check("rw_next_resp", resp_valid, 2'b01);
    check("rw_next_rdata", resp_rdata, 32'h00000055);

`ifdef HANSEN_ARB_LOCK_EN
    // req1 keeps the bus for three transactions while req0 waits
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mem_ready = 1'b1; mem_rvalid = 1'b1; req_lock = 2'b10; req_valid = 2'b10; #1;
    check("lk_grant0", req_ready, 2'b10);
    tick(); req_valid = 2'b11;
    tick();
    check("lk_grant1", req_ready, 2'b10);
    tick();
    tick();
    check("lk_grant2", req_ready, 2'b10);
    tick(); req_lock = '0;
    tick();
    check("lk_release", req_ready, 2'b01);
    tick(); req_valid = '0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
